// File: rtl/reg_bus_regfile_pkg.sv
// Shared types and address decode for the register-bus responder.
// Optional lock register is enabled with REG_BUS_REGFILE_LOCK_EN.
package reg_bus_regfile_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int BYTE_OFFS_W = 2;

   // Flags misaligned, out-of-range or upper-bit-aliased byte addresses.
   function automatic logic addr_err(input logic [63:0] addr,
                                     input int          idx_w,
                                     input int          num_regs);
      logic [63:0] idx_full;
      logic [63:0] upper;
      idx_full = (addr >> BYTE_OFFS_W) & ((64'd1 << idx_w) - 64'd1);
      upper    = addr >> (BYTE_OFFS_W + idx_w);
      return (addr[1:0] != 2'b00) || (idx_full >= 64'(num_regs)) || (upper != 64'd0);
   endfunction

endpackage

// File: rtl/reg_bus_regfile_if.sv
// Valid/ready register bus: initiator drives the request, responder returns a registered response.
interface reg_bus_regfile_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    write;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    valid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    error;
   logic                    ready;

   modport master (
      output addr, write, wdata, wstrb, valid,
      input  rdata, error, ready
   );

   modport slave (
      input  addr, write, wdata, wstrb, valid,
      output rdata, error, ready
   );
endinterface

// File: rtl/reg_bus_regfile_cell.sv
// One data word with per-byte write enables and asynchronous active-low reset.
module reg_bus_regfile_cell
   import reg_bus_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   q_o
);

   logic [DATA_WIDTH-1:0] q_q;
   logic [DATA_WIDTH-1:0] q_d;

   for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte
      assign q_d[gi*8 +: 8] = (we_i && be_i[gi]) ? wdata_i[gi*8 +: 8] : q_q[gi*8 +: 8];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/reg_bus_regfile.sv
// Register-bus responder mapping NUM_REGS words with byte strobes, read-only slots and error reporting.
// Define REG_BUS_REGFILE_LOCK_EN to turn the last register into a write-lock for all others.
module reg_bus_regfile
   import reg_bus_regfile_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 8,
   parameter int                    WAIT_CYCLES = 1,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   reg_bus_regfile_if.slave               bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d_i
);

   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_WAIT = WAIT;
   localparam logic [1:0] S_RESP = RESP;

`ifdef REG_BUS_REGFILE_LOCK_EN
   localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(1) << (NUM_REGS - 1));
`else
   localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  go_resp;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic                  cur_write;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic [STRB_W-1:0]     cur_wstrb;
   logic [IDX_W-1:0]      idx;
   logic                  dec_err;
   logic                  locked;
   logic                  txn_err;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [NUM_REGS-1:0]   wr_en;
   logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      go_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.valid) begin
               addr_d  = bus.addr;
               write_d = bus.write;
               wdata_d = bus.wdata;
               wstrb_d = bus.wstrb;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            // A withdrawn request is abandoned silently.
            if (!bus.valid) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // With no wait states the commit happens straight from the live request.
   always_comb begin
      if (state_q == S_IDLE) begin
         cur_addr  = bus.addr;
         cur_write = bus.write;
         cur_wdata = bus.wdata;
         cur_wstrb = bus.wstrb;
      end else begin
         cur_addr  = addr_q;
         cur_write = write_q;
         cur_wdata = wdata_q;
         cur_wstrb = wstrb_q;
      end
   end

   assign idx     = cur_addr[BYTE_OFFS_W +: IDX_W];
   assign dec_err = addr_err(64'(cur_addr), IDX_W, NUM_REGS);

`ifdef REG_BUS_REGFILE_LOCK_EN
   logic lock_q, lock_d;

   assign locked = lock_q && (idx != IDX_W'(NUM_REGS - 1));

   always_comb begin
      lock_d = lock_q;
      if (wr_en[NUM_REGS-1] && cur_wstrb[0]) begin
         lock_d = cur_wdata[0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end
`else
   assign locked = 1'b0;
`endif

   assign txn_err = dec_err || (cur_write && (RO_EFF[idx] || locked));
   assign rd_val  = RO_EFF[idx] ? hw_d_i[idx*DATA_WIDTH +: DATA_WIDTH] : reg_val[idx];

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      assign wr_en[gi] = go_resp && cur_write && !txn_err && (idx == IDX_W'(gi));
`ifdef REG_BUS_REGFILE_LOCK_EN
      if (gi == NUM_REGS - 1) begin : g_lock
         assign reg_val[gi] = {{(DATA_WIDTH-1){1'b0}}, lock_q};
      end else
`endif
      if (RO_EFF[gi]) begin : g_ro
         assign reg_val[gi] = hw_d_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
         reg_bus_regfile_cell #(
            .DATA_WIDTH(DATA_WIDTH)
         ) u_cell (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .we_i   (wr_en[gi]),
            .be_i   (cur_wstrb),
            .wdata_i(cur_wdata),
            .q_o    (reg_val[gi])
         );
      end
      assign reg_q_o[gi*DATA_WIDTH +: DATA_WIDTH] = reg_val[gi];
   end

   always_comb begin
      ready_d = go_resp;
      error_d = error_q;
      rdata_d = rdata_q;
      if (go_resp) begin
         error_d = txn_err;
         rdata_d = (txn_err || cur_write) ? '0 : rd_val;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         ready_q <= ready_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.error = error_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_reg_bus_regfile.sv
// Directed bench for reg_bus_regfile with a transaction-level register model and a per-cycle compare.
module tb_reg_bus_regfile;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam int WC = 1;
   localparam logic [NR-1:0] RO = 8'h04;
`ifdef REG_BUS_REGFILE_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_bus_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   logic [NR*DW-1:0] reg_q;
   logic [NR*DW-1:0] hw_d;

   reg_bus_regfile #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_REGS   (NR),
      .WAIT_CYCLES(WC),
      .RO_MASK    (RO)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .reg_q_o(reg_q),
      .hw_d_i (hw_d)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: architectural register values plus the one outstanding response.
   logic [31:0] m_regs [NR];
   int          exp_rdy = -1;
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic        pend_we = 1'b0;
   int          pend_idx = 0;
   logic [31:0] pend_val;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always begin
      @(posedge clk);
      #3;
      if (rst_n) begin
         if (cyc == exp_rdy) begin
            if (pend_we) m_regs[pend_idx] = pend_val;
            check("ready_pulse", 32'(bus.ready), 32'd1);
            check("rdata", bus.rdata, exp_rdata);
            check("error", 32'(bus.error), 32'(exp_err));
         end else begin
            check("ready_quiet", 32'(bus.ready), 32'd0);
         end
         for (int i = 0; i < NR; i++) begin
            if (!RO[i] || (LOCK && i == NR - 1)) begin
               check($sformatf("reg_q[%0d]", i), reg_q[i*DW +: DW], m_regs[i]);
            end
         end
      end
   end

   task automatic txn(input logic [7:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er);
      int          idx;
      logic        e;
      logic        ro;
      logic [31:0] nv;
      @(negedge clk);
      idx = int'(a) >> 2;
      e   = (a[1:0] != 2'b00) || (idx >= NR);
      ro  = 1'b0;
      if (!e) ro = RO[idx] && !(LOCK && idx == NR - 1);
      if (!e && w && ro) e = 1'b1;
      if (!e && w && LOCK && m_regs[NR-1][0] && idx != NR - 1) e = 1'b1;
      pend_we  = w && !e;
      pend_idx = e ? 0 : idx;
      if (pend_we) begin
         nv = m_regs[idx];
         for (int k = 0; k < 4; k++) if (st[k]) nv[8*k +: 8] = wd[8*k +: 8];
         if (LOCK && idx == NR - 1) nv = nv & 32'h1;
         pend_val = nv;
      end
      exp_err = e;
      if (e || w)  exp_rdata = 32'h0;
      else if (ro) exp_rdata = hw_d[idx*DW +: DW];
      else         exp_rdata = m_regs[idx];
      bus.addr  = a;
      bus.write = w;
      bus.wdata = wd;
      bus.wstrb = st;
      bus.valid = 1'b1;
      exp_rdy   = cyc + WC + 1;
      repeat (WC + 1) @(posedge clk);
      #3;
      rd = bus.rdata;
      er = bus.error;
      $display("txn addr=%h we=%0d wdata=%h strb=%b -> rdata=%h err=%0d", a, w, wd, st, rd, er);
      @(negedge clk);
      bus.valid = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = 32'h0;
         hw_d[i*DW +: DW] = 32'h1000_0000 + i;
      end
      hw_d[2*DW +: DW] = 32'hCAFE_0001;
      bus.addr = '0; bus.write = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.valid = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_reg1", reg_q[1*DW +: DW], 32'h0);
      rst_n = 1'b1;

      txn(8'h04, 1'b1, 32'hDEADBEEF, 4'hF, rd, er);
      check("t1_err", 32'(er), 32'd0);
      check("t1_reg1", reg_q[1*DW +: DW], 32'hDEADBEEF);

      txn(8'h04, 1'b1, 32'h11223344, 4'b0101, rd, er);
      txn(8'h04, 1'b0, 32'h0, 4'h0, rd, er);
      check("t2_rdata", rd, 32'hDE22BE44);
      check("t2_err", 32'(er), 32'd0);

      txn(8'h08, 1'b0, 32'h0, 4'h0, rd, er);
      check("t3_ro_read", rd, 32'hCAFE0001);
      txn(8'h08, 1'b1, 32'h12345678, 4'hF, rd, er);
      check("t3_ro_write_err", 32'(er), 32'd1);
      txn(8'h08, 1'b0, 32'h0, 4'h0, rd, er);
      check("t3_ro_after", rd, 32'hCAFE0001);

      txn(8'h0C, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er);
      check("nostrb_err", 32'(er), 32'd0);
      check("nostrb_reg3", reg_q[3*DW +: DW], 32'h0);

      txn(8'h20, 1'b0, 32'h0, 4'h0, rd, er);
      check("t4_range_err", 32'(er), 32'd1);
      check("t4_range_rdata", rd, 32'h0);
      txn(8'h03, 1'b0, 32'h0, 4'h0, rd, er);
      check("t4_align_err", 32'(er), 32'd1);
      txn(8'h06, 1'b1, 32'h0BADF00D, 4'hF, rd, er);
      check("t4_align_wr_err", 32'(er), 32'd1);
      check("t4_reg1_kept", reg_q[1*DW +: DW], 32'hDE22BE44);

      // Withdrawn write: request dropped during the wait state.
      txn(8'h0C, 1'b1, 32'h00005A5A, 4'hF, rd, er);
      @(negedge clk);
      bus.addr = 8'h0C; bus.write = 1'b1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.valid = 1'b1;
      @(negedge clk);
      bus.valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_abort_keep", reg_q[3*DW +: DW], 32'h00005A5A);
      $display("txn addr=0c we=1 aborted in wait");

      txn(8'h0C, 1'b0, 32'h0, 4'h0, rd, er);
      check("t5_read3", rd, 32'h00005A5A);

      // Reset asserted while a write sits in the wait state.
      @(negedge clk);
      bus.addr = 8'h04; bus.write = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      bus.valid = 1'b0;
      exp_rdy = -1;
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      #1;
      check("t5_rst_ready", 32'(bus.ready), 32'd0);
      check("t5_rst_error", 32'(bus.error), 32'd0);
      check("t5_rst_rdata", bus.rdata, 32'h0);
      check("t5_rst_reg1", reg_q[1*DW +: DW], 32'h0);
      check("t5_rst_reg3", reg_q[3*DW +: DW], 32'h0);
      $display("txn reset pulsed mid-wait");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t5_no_late_ready", 32'(bus.ready), 32'd0);
      txn(8'h04, 1'b0, 32'h0, 4'h0, rd, er);
      check("t5_read1_zero", rd, 32'h0);

      txn(8'h1C, 1'b1, 32'hA5A5A5A5, 4'hF, rd, er);
      txn(8'h1C, 1'b0, 32'h0, 4'h0, rd, er);
`ifdef REG_BUS_REGFILE_LOCK_EN
      check("reg7_lockbit", rd, 32'h1);
      txn(8'h1C, 1'b1, 32'h00000001, 4'hF, rd, er);
      check("t6_lock_set_err", 32'(er), 32'd0);
      txn(8'h00, 1'b1, 32'hDEADBEEF, 4'hF, rd, er);
      check("t6_locked_err", 32'(er), 32'd1);
      check("t6_locked_reg0", reg_q[0 +: DW], 32'h0);
      txn(8'h1C, 1'b1, 32'h00000000, 4'hF, rd, er);
      check("t6_unlock_err", 32'(er), 32'd0);
      txn(8'h00, 1'b1, 32'h13579BDF, 4'hF, rd, er);
      check("t6_unlocked_err", 32'(er), 32'd0);
      txn(8'h00, 1'b0, 32'h0, 4'h0, rd, er);
      check("t6_unlocked_read", rd, 32'h13579BDF);
`else
      check("reg7_plain", rd, 32'hA5A5A5A5);
      txn(8'h00, 1'b1, 32'h13579BDF, 4'hF, rd, er);
      check("reg0_write_err", 32'(er), 32'd0);
      txn(8'h00, 1'b0, 32'h0, 4'h0, rd, er);
      check("reg0_read", rd, 32'h13579BDF);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
